// File: rtl/uart_rx_top_if.sv
// rtl/uart_rx_top_if.sv - serial line, rate select and byte-report handshake bundle for uart_rx_top
interface uart_rx_top_if;
    logic [1:0] baudsel;
    logic       rx_in;
    logic       rd;
    logic [7:0] d_out;
    logic       rx_ready;
    logic       rx_status;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    modport master (
        output baudsel, rx_in, rd,
        input  d_out, rx_ready, rx_status, frame_err, overrun, parity_err
    );

    modport slave (
        input  baudsel, rx_in, rd,
        output d_out, rx_ready, rx_status, frame_err, overrun, parity_err
    );
endinterface

// File: rtl/uart_rx_top.sv
// rtl/uart_rx_top.sv - 16x-oversampling 8N1 UART receiver; even parity bit added when UART_RX_PARITY_EN is defined
module uart_rx_top #(
    parameter int unsigned DIV0 = 1302,
    parameter int unsigned DIV1 = 651,
    parameter int unsigned DIV2 = 326,
    parameter int unsigned DIV3 = 163
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_top_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [15:0] div_q, div_d, div_sel;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  scnt_q, scnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  d_out_q, d_out_d;
    logic        rx_ready_q, rx_ready_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        done;
    logic        tick;
    logic        rxs;

`ifdef UART_RX_PARITY_EN
    logic        par_q, par_d;
    logic        parity_err_q, parity_err_d;
`endif

    assign rxs = sync2_q;

    always_comb begin
        case (bus.baudsel)
            2'b00:   div_sel = 16'(DIV0);
            2'b01:   div_sel = 16'(DIV1);
            2'b10:   div_sel = 16'(DIV2);
            default: div_sel = 16'(DIV3);
        endcase
    end

    // The tick counter is parked at 0 in IDLE so the first tick of a frame
    // lands exactly one divisor period after the start edge.
    assign tick = (state_q != S_IDLE) && (cnt_q == div_q - 16'd1);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_d       = (state_q == S_IDLE || tick) ? 16'd0 : cnt_q + 16'd1;
        scnt_d      = scnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        d_out_d     = d_out_q;
        rx_ready_d  = rx_ready_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        done        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = parity_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                div_d = div_sel;
                if (!rxs) begin
                    state_d = S_START;
                    scnt_d  = 4'd0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (scnt_q == 4'd7) begin
                        scnt_d  = 4'd0;
                        bit_d   = 3'd0;
                        state_d = rxs ? S_IDLE : S_DATA;
                    end else begin
                        scnt_d = scnt_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) begin
                        shift_d = {rxs, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) begin
                        par_d   = rxs;
                        state_d = S_STOP;
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) begin
                        if (rxs) begin
                            done        = 1'b1;
                            frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                            parity_err_d = ^{shift_q, par_q};
`endif
                            state_d = S_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_BRK;
                        end
                    end
                end
            end
            S_BRK: begin
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A completing byte beats a simultaneous read: it is delivered unread.
        if (done) begin
            d_out_d    = shift_q;
            rx_ready_d = 1'b1;
            overrun_d  = rx_ready_q & ~bus.rd;
        end else if (bus.rd && rx_ready_q) begin
            rx_ready_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            div_q       <= 16'(DIV0);
            cnt_q       <= 16'd0;
            scnt_q      <= 4'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            d_out_q     <= 8'h00;
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= bus.rx_in;
            sync2_q     <= sync1_q;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            scnt_q      <= scnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            d_out_q     <= d_out_d;
            rx_ready_q  <= rx_ready_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.d_out     = d_out_q;
    assign bus.rx_ready  = rx_ready_q;
    assign bus.rx_status = (state_q != S_IDLE);
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_top.sv
// tb/tb_uart_rx_top.sv - directed table-driven bench for uart_rx_top with shortened divisors
module tb_uart_rx_top;

    localparam int D0 = 20;
    localparam int D1 = 12;
    localparam int D2 = 8;
    localparam int D3 = 5;
`ifdef UART_RX_PARITY_EN
    localparam int TICKS = 168;
`else
    localparam int TICKS = 152;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   n;

    uart_rx_top_if bus ();

    uart_rx_top #(.DIV0(D0), .DIV1(D1), .DIV2(D2), .DIV3(D3)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        bit         pre_rd;
        logic [7:0] data;
        bit         stop;
        logic [7:0] exp_d;
        bit         exp_rdy;
        bit         exp_fe;
        bit         exp_ov;
    } vec_t;

    vec_t vt[7];

    function automatic int bitclk(input logic [1:0] sel);
        case (sel)
            2'b00:   return 16 * D0;
            2'b01:   return 16 * D1;
            2'b10:   return 16 * D2;
            default: return 16 * D3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_clk(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input bit stop, input bit par, input int b);
        bus.rx_in = 1'b0;
        wait_clk(b);
        for (int i = 0; i < 8; i++) begin
            bus.rx_in = data[i];
            wait_clk(b);
        end
`ifdef UART_RX_PARITY_EN
        bus.rx_in = par;
        wait_clk(b);
`else
        if (par) bus.rx_in = 1'b1;
`endif
        bus.rx_in = stop;
        wait_clk(b);
        bus.rx_in = 1'b1;
        wait_clk(b);
    endtask

    task automatic pulse_rd();
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic [7:0] d, input bit rdy, input bit fe, input bit ov);
        chk({tag, ".d_out"}, bus.d_out, d);
        chk({tag, ".rx_ready"}, {7'd0, bus.rx_ready}, {7'd0, rdy});
        chk({tag, ".frame_err"}, {7'd0, bus.frame_err}, {7'd0, fe});
        chk({tag, ".overrun"}, {7'd0, bus.overrun}, {7'd0, ov});
        chk({tag, ".parity_err"}, {7'd0, bus.parity_err}, 8'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vt[0] = '{2'b10, 1'b0, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        vt[1] = '{2'b10, 1'b1, 8'h3C, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
        vt[2] = '{2'b10, 1'b0, 8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0};
        vt[3] = '{2'b10, 1'b1, 8'h11, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
        vt[4] = '{2'b10, 1'b0, 8'h22, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
        vt[5] = '{2'b11, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        vt[6] = '{2'b00, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};

        rst_n       = 1'b0;
        bus.rx_in   = 1'b1;
        bus.rd      = 1'b0;
        bus.baudsel = 2'b10;
        wait_clk(5);
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reset.rx_status", {7'd0, bus.rx_status}, 8'd0);
        rst_n = 1'b1;
        wait_clk(10);

        // First-frame latency: about 9.5 bit times from the start edge
        n = 0;
        fork
            send_frame(8'hC3, 1'b1, ^8'hC3, bitclk(2'b10));
            begin
                while (!bus.rx_ready && n < TICKS * D2 + 200) begin
                    @(negedge clk);
                    n++;
                    if (n == 3 * 16 * D2)
                        chk("busy.rx_status", {7'd0, bus.rx_status}, 8'd1);
                end
            end
        join
        chk_range("latency", n, TICKS * D2, TICKS * D2 + 5);
        chk_all("first", 8'hC3, 1'b1, 1'b0, 1'b0);
        chk("first.rx_status", {7'd0, bus.rx_status}, 8'd0);
        pulse_rd();
        chk("rd_clears.rx_ready", {7'd0, bus.rx_ready}, 8'd0);
        pulse_rd();
        chk_all("idle_rd", 8'hC3, 1'b0, 1'b0, 1'b0);

        // Short low glitch well under half a bit must be rejected
        bus.rx_in = 1'b0;
        wait_clk(40);
        bus.rx_in = 1'b1;
        wait_clk(2 * bitclk(2'b10));
        chk("glitch.rx_status", {7'd0, bus.rx_status}, 8'd0);
        chk_all("glitch", 8'hC3, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 7; i++) begin
            bus.baudsel = vt[i].sel;
            if (vt[i].pre_rd) pulse_rd();
            wait_clk(4);
            send_frame(vt[i].data, vt[i].stop, ^vt[i].data, bitclk(vt[i].sel));
            wait_clk(bitclk(vt[i].sel));
            chk_all($sformatf("vec%0d", i), vt[i].exp_d, vt[i].exp_rdy, vt[i].exp_fe, vt[i].exp_ov);
        end
        pulse_rd();
        chk("ovr_rd.rx_ready", {7'd0, bus.rx_ready}, 8'd0);
        chk("ovr_rd.overrun", {7'd0, bus.overrun}, 8'd0);

        // Read strobe coinciding with byte completion: new byte stays unread
        bus.baudsel = 2'b10;
        wait_clk(4);
        send_frame(8'h44, 1'b1, ^8'h44, bitclk(2'b10));
        chk("pre_coll.rx_ready", {7'd0, bus.rx_ready}, 8'd1);
        fork
            send_frame(8'h6E, 1'b1, ^8'h6E, bitclk(2'b10));
            begin
                wait_clk(2 + TICKS * D2);
                bus.rd = 1'b1;
                @(negedge clk);
                bus.rd = 1'b0;
            end
        join
        chk_all("coll", 8'h6E, 1'b1, 1'b0, 1'b0);

        // Reset during data bit 4 of 0xFF
        bus.rx_in = 1'b0;
        wait_clk(bitclk(2'b10));
        bus.rx_in = 1'b1;
        wait_clk(4 * bitclk(2'b10) + bitclk(2'b10) / 2);
        rst_n = 1'b0;
        wait_clk(3);
        chk_all("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("midrst.rx_status", {7'd0, bus.rx_status}, 8'd0);
        wait_clk(6 * bitclk(2'b10));
        rst_n = 1'b1;
        wait_clk(10);
        chk_all("post_rst_idle", 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(8'h81, 1'b1, ^8'h81, bitclk(2'b10));
        chk_all("after_rst", 8'h81, 1'b1, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
        bus.baudsel = 2'b11;
        pulse_rd();
        wait_clk(4);
        send_frame(8'h07, 1'b1, 1'b1, bitclk(2'b11));
        chk("par_ok.parity_err", {7'd0, bus.parity_err}, 8'd0);
        chk("par_ok.d_out", bus.d_out, 8'h07);
        pulse_rd();
        send_frame(8'h07, 1'b1, 1'b0, bitclk(2'b11));
        chk("par_bad.parity_err", {7'd0, bus.parity_err}, 8'd1);
        chk("par_bad.rx_ready", {7'd0, bus.rx_ready}, 8'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_top.md
Name: uart_rx_top

Overview:
- Receive-side counterpart to the UART transmit top: internal 16x-oversampling baud tick generator plus receiver FSM in one clock domain.
- Converts the asynchronous serial line into 8-bit parallel bytes. Frame format is 1 start bit, 8 data bits LSB first, 1 stop bit.
- Reports each byte through a ready/read handshake, with framing and overrun flags.
- Sits beside the transmitter top and uses the same baudsel encoding, so both ends agree on rate.

Parameters:
- DIV0, 1302, clk cycles per 16x tick for baudsel=00 (2400 baud at 50 MHz)
- DIV1, 651, clk cycles per 16x tick for baudsel=01 (4800 baud)
- DIV2, 326, clk cycles per 16x tick for baudsel=10 (9600 baud)
- DIV3, 163, clk cycles per 16x tick for baudsel=11 (19200 baud)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- baudsel  input  2  baud rate select; same encoding as the transmitter
- rx_in  input  1  serial line; idles high; asynchronous to clk
- rd  input  1  read strobe; a 1-cycle pulse acknowledges d_out
- d_out  output  8  last received byte
- rx_ready  output  1  byte available and not yet read
- rx_status  output  1  high while a frame is in progress (any state except IDLE)
- frame_err  output  1  stop bit of the last frame sampled low
- overrun  output  1  a new byte overwrote an unread byte
- parity_err  output  1  parity mismatch; see Optional Feature

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE; all outputs = 0; d_out = 8'h00.
  - Synchronizer flops = 1; tick counter = 0.
- rx_in synchronization: two flops, then used as rxs.
- Tick generator:
  - Divisor is selected by baudsel, latched into div_q while in IDLE.
  - A change to baudsel mid-frame takes effect on the next frame.
  - Counter counts 0..div_q-1 and emits a 1-clk tick at the wrap.
  - Counter restarts at 0 when a start edge is detected.
- FSM, all advances on tick; sample counter scnt 0..15:
  - IDLE: rxs=0 (checked every clk) -> START, scnt=0, tick counter cleared.
  - START: at scnt=7 (mid-bit): rxs=0 -> DATA with scnt=0, bit=0; rxs=1 -> IDLE (glitch rejected, no flags change).
  - DATA: at scnt=15, sample rxs into shift register MSB, shifting right (LSB first). After bit 7 -> STOP (or PARITY if enabled).
  - STOP: at scnt=15:
    - rxs=1: d_out <= shift register; rx_ready <= 1; frame_err <= 0 -> IDLE.
    - rxs=0: frame_err <= 1; d_out and rx_ready unchanged -> BRK.
  - BRK: wait until rxs=1 -> IDLE (a held-low line produces no repeated frames).
- Latency: rx_ready rises 1 clk after the stop-bit mid-sample tick.
- rd handshake:
  - rd=1 clears rx_ready and overrun on the next clk edge.
  - rd while rx_ready=0 is ignored.
- Overrun: a byte completes while rx_ready=1 and rd=0 -> d_out overwritten, overrun <= 1, rx_ready stays 1.
- rd in the same cycle a byte completes: the new byte wins; rx_ready=1, overrun=0.
- frame_err is sticky until the next successfully stopped frame or reset.
- Reset mid-frame aborts the frame immediately; no partial byte is ever visible on d_out.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA; one even-parity bit is sampled at scnt=15.
  - At STOP success, parity_err <= (XOR of the 8 data bits and the parity bit). The byte is still delivered with rx_ready.
  - Frame length is 11 bits.
- Undefined:
  - No PARITY state; frame length is 10 bits.
  - parity_err is tied to 0.

Test Plan:
- Baudsel=10 (bit = 5216 clk), send 0xA5 with stop=1 -> d_out=8'hA5, rx_ready=1 about 9.5 bits after the start edge, frame_err=0, rx_status low afterwards; pulse rd -> rx_ready=0.
- Low glitch of 2000 clk (< half bit) on an idle line -> FSM returns to IDLE, rx_ready/frame_err stay 0, d_out unchanged.
- Send 0x3C with stop bit driven 0, then line high -> frame_err=1, rx_ready=0, d_out keeps its previous value; next good frame 0x5A -> d_out=8'h5A, frame_err=0.
- Send 0x11 then 0x22 back-to-back without rd -> d_out=8'h22, rx_ready=1, overrun=1; rd -> both clear.
- Assert rst low at data bit 4 of 0xFF, release, then send 0x81 -> outputs 0 during reset, then d_out=8'h81, no error flags.
- With UART_RX_PARITY_EN, baudsel=11: send 0x07 with parity 1 -> parity_err=0; send 0x07 with parity 0 -> parity_err=1, rx_ready=1.
